// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e;

  localparam int unsigned DW_DEFAULT = 8;

  // Iteration counter width; never narrower than one bit.
  function automatic int unsigned count_width(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// start/ready handshake plus operand and result buses of the sequential divider.
interface seq_divider_if #(
  parameter int unsigned DW = div_pkg::DW_DEFAULT
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          ready;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, ready, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, ready, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract.
module div_step #(
  parameter int unsigned DW = div_pkg::DW_DEFAULT
) (
  input  logic [DW:0]   r,
  input  logic          q_msb,
  input  logic [DW-1:0] d,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW+1:0] shifted;
  logic [DW+1:0] diff;

  // One extra guard bit so the borrow is visible even for a full-width shift.
  always_comb begin
    shifted = {r, q_msb};
    diff    = shifted - {2'b00, d};
    q_bit   = ~diff[DW+1];
    r_next  = diff[DW+1] ? shifted[DW:0] : diff[DW:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/ready handshake.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned CW = count_width(DW);

  div_state_e    state, state_n;
  logic [DW:0]   r_q;
  logic [DW-1:0] q_q;
  logic [DW-1:0] d_q;
  logic [CW-1:0] cnt_q;

  logic          busy_q;
  logic          ready_q;
  logic [DW-1:0] quotient_q;
  logic [DW-1:0] remainder_q;
  logic          dbz_q;

  logic [DW:0]   r_nxt;
  logic [DW-1:0] q_nxt;
  logic          q_bit;
  logic          accept_c;
  logic          last_c;
  logic          zero_div_c;

  div_step #(.DW(DW)) u_step (
    .r      (r_q),
    .q_msb  (q_q[DW-1]),
    .d      (d_q),
    .r_next (r_nxt),
    .q_bit  (q_bit)
  );

  assign q_nxt = (q_q << 1) | DW'(q_bit);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_n    = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    zero_div_c = (bus.divisor == '0);
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_n  = zero_div_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CW'(DW - 1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs; results only move on accept (div-by-zero) or final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      busy_q  <= (state_n != IDLE);
      ready_q <= (state_n == DONE);
      if (accept_c) begin
        r_q   <= '0;
        q_q   <= bus.dividend;
        d_q   <= bus.divisor;
        cnt_q <= '0;
        if (zero_div_c) begin
          quotient_q  <= '1;
          remainder_q <= bus.dividend;
          dbz_q       <= 1'b1;
        end
      end else if (state == CALC) begin
        r_q   <= r_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q + CW'(1);
        if (last_c) begin
          quotient_q  <= q_nxt;
          remainder_q <= r_nxt[DW-1:0];
          dbz_q       <= 1'b0;
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.ready       = ready_q;
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;

  localparam int unsigned DW = 8;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.DW(DW)) dif ();

  seq_divider #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one division from IDLE and check latency, results, invariant and pulse width.
  task automatic run_div(input logic [DW-1:0] a, input logic [DW-1:0] b, input string tag);
    logic [DW-1:0] eq, er;
    int            lat, elat;
    eq   = (b == 0) ? {DW{1'b1}} : DW'(a / b);
    er   = (b == 0) ? a : DW'(a % b);
    elat = (b == 0) ? 0 : DW;
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    step();
    dif.start    = 1'b0;
    dif.dividend = DW'($urandom);
    dif.divisor  = DW'($urandom);
    lat = 0;
    while (!dif.ready && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, 32'(dif.quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(dif.remainder), 32'(er));
    check({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(b == 0));
    if (b != 0) begin
      check({tag, "_invariant"}, 32'(dif.quotient) * 32'(b) + 32'(dif.remainder), 32'(a));
      check({tag, "_rem_lt_div"}, 32'(dif.remainder < b), 32'd1);
    end
    step();
    check({tag, "_ready_one_cycle"}, 32'(dif.ready), 32'd0);
    check({tag, "_idle_busy"}, 32'(dif.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, t, t1, t2;
    logic [DW-1:0] cq, cr;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    step();
    step();
    check("reset_busy", 32'(dif.busy), 32'd0);
    check("reset_ready", 32'(dif.ready), 32'd0);
    check("reset_quotient", 32'(dif.quotient), 32'd0);
    check("reset_remainder", 32'(dif.remainder), 32'd0);
    check("reset_dbz", 32'(dif.div_by_zero), 32'd0);
    rst = 1'b0;
    step();

    run_div(8'd255, 8'd7, "d255_7");
    run_div(8'h55, 8'h7F, "d55_7f");
    run_div(8'h55, 8'h55, "d55_55");
    run_div(8'd100, 8'd0, "d100_0");
    run_div(8'd100, 8'd10, "d100_10");

    // New start and operands during CALC must not disturb the running division.
    dif.start    = 1'b1;
    dif.dividend = 8'd200;
    dif.divisor  = 8'd3;
    step();
    dif.start = 1'b0;
    pulses = 0;
    cq = '0;
    cr = '0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        dif.start    = 1'b1;
        dif.dividend = 8'd9;
        dif.divisor  = 8'd2;
      end
      if (i == 6) dif.start = 1'b0;
      step();
      if (dif.ready) begin
        pulses++;
        cq = dif.quotient;
        cr = dif.remainder;
      end
    end
    check("midcalc_pulses", 32'(pulses), 32'd1);
    check("midcalc_quotient", 32'(cq), 32'd66);
    check("midcalc_remainder", 32'(cr), 32'd2);

    // Abandon 255/7 at count 4 via reset.
    dif.start    = 1'b1;
    dif.dividend = 8'd255;
    dif.divisor  = 8'd7;
    step();
    dif.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("pre_reset_busy", 32'(dif.busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midreset_busy", 32'(dif.busy), 32'd0);
    check("midreset_ready", 32'(dif.ready), 32'd0);
    check("midreset_quotient", 32'(dif.quotient), 32'd0);
    check("midreset_remainder", 32'(dif.remainder), 32'd0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dif.ready) pulses++;
    end
    check("midreset_no_pulse", 32'(pulses), 32'd0);
    run_div(8'd255, 8'd255, "d255_255");

    // Start held high: back-to-back results one every DW+2 cycles.
    dif.start    = 1'b1;
    dif.dividend = 8'd50;
    dif.divisor  = 8'd7;
    t  = 0;
    t1 = -1;
    t2 = -1;
    while (t2 < 0 && t < 60) begin
      step();
      t++;
      if (dif.ready) begin
        if (t1 < 0) t1 = t;
        else        t2 = t;
      end
    end
    dif.start = 1'b0;
    check("b2b_interval", 32'(t2 - t1), 32'(DW + 2));
    check("b2b_quotient", 32'(dif.quotient), 32'd7);
    check("b2b_remainder", 32'(dif.remainder), 32'd1);
    t = 0;
    while (dif.busy && t < 40) begin
      step();
      t++;
    end
    check("b2b_drain", 32'(dif.busy), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      logic [DW-1:0] a, b;
      a = DW'($urandom);
      b = (($urandom % 16) == 0) ? DW'(0) : DW'($urandom);
      run_div(a, b, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned restoring divider, the inverse counterpart of the team's shift-add sequential multiplier.
- Uses the same start/ready handshake and the same DW parameterisation, so both blocks plug into one arithmetic unit.
- Retires one quotient bit per clock and reports quotient, remainder and a divide-by-zero flag.

Parameters:
- DW, 8, operand width in bits for dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  DW  unsigned dividend; captured on the accepting edge.
- divisor  input  DW  unsigned divisor; captured on the accepting edge.
- busy  output  1  high while in CALC or DONE.
- ready  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  DW  result quotient; held until the next accepted start.
- remainder  output  DW  result remainder; held until the next accepted start.
- div_by_zero  output  1  set together with results when the captured divisor is 0.

Behaviour:
- Reset: state=IDLE, busy=0, ready=0, quotient=0, remainder=0, div_by_zero=0, internal registers and count cleared.
- Reset wins over all other events, including mid-CALC; an operation in flight is abandoned without a ready pulse.
- IDLE with start=1 at edge E:
  - Captures operands into dividend shift reg Q, divisor reg D and partial remainder R=0 (DW+1 bits); sets count=0.
  - Divisor!=0: goes to CALC.
  - Divisor==0: goes straight to DONE with quotient={DW{1}}, remainder=dividend, div_by_zero=1.
- CALC, each edge:
  - Shift {R,Q} left by 1, forming T=R-D.
  - T non-negative (MSB 0): R=T, Q[0]=1. Otherwise R unchanged (restored), Q[0]=0.
  - count increments. When count==DW-1 the final step registers quotient=Q, remainder=R[DW-1:0], div_by_zero=0, and goes to DONE.
- DONE: ready=1 for exactly this cycle; the next edge goes to IDLE.
- Latency, normal case: ready is high in the cycle after edge E+DW, i.e. DW+1 cycles after start is sampled. Divide-by-zero: ready is high in the cycle after edge E.
- start is ignored while busy=1. start high in the DONE cycle is ignored; start held high then re-triggers on the following IDLE cycle (back-to-back throughput: one result per DW+2 cycles).
- Operands may change after E without affecting the result.
- Outputs quotient, remainder and div_by_zero are registered and stable between ready pulses.
- Arithmetic is unsigned. Invariant: dividend == quotient*divisor + remainder with remainder < divisor, for divisor != 0.

Decomposition:
- Package div_pkg:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_e.
  - Localparam DW_DEFAULT=8.
  - Function clog2-based width helper for count (width $clog2(DW)).
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: R (DW+1), Q msb, D.
  - Outputs: next R and quotient bit.
  - Keeps the FSM and datapath of seq_divider separate and testable alone.

Test Plan:
- dividend=255, divisor=7, start pulse 1 cycle -> ready pulse in the cycle after edge E+8; quotient=36, remainder=3, div_by_zero=0.
- dividend=0x55, divisor=0x7F -> quotient=0, remainder=85; then dividend=0x55, divisor=0x55 -> quotient=1, remainder=0.
- dividend=100, divisor=0 -> ready in the cycle after edge E; quotient=0xFF, remainder=100, div_by_zero=1. Next division 100/10 -> quotient=10, remainder=0, div_by_zero=0.
- start re-asserted and operands changed (to 9/2) during CALC of 200/3 -> result still quotient=66, remainder=2; exactly one ready pulse; 9/2 not executed unless start is still high in IDLE.
- rst=1 for one cycle at CALC count=4 of 255/7 -> next cycle busy=0, ready=0, quotient=0, remainder=0, no ready pulse. A following 255/255 -> quotient=1, remainder=0.
- Randomised sweep of 1000 operand pairs with DW=8 -> every result satisfies dividend == quotient*divisor + remainder and remainder < divisor.
